// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default slot geometry and word-select polarity,
// common to the transmitter and receiver.
package i2s_pkg;

  localparam int unsigned SLOT_WIDTH_DEF = 32;
  localparam int unsigned FRAME_BITS_DEF = 2 * SLOT_WIDTH_DEF;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_transmitter_if.sv
// PCM pair handshake plus I2S link and status signals of the transmitter.
interface i2s_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 24
);

  logic [DATA_WIDTH-1:0] left_in;
  logic [DATA_WIDTH-1:0] right_in;
  logic                  data_valid_in;
  logic                  ready_out;
  logic                  sclk_out;
  logic                  ws_out;
  logic                  sdata_out;
  logic                  frame_start_out;
  logic                  underrun_out;

  // Upstream sample source / link consumer
  modport master (
    output left_in, right_in, data_valid_in,
    input  ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out
  );

  // Transmitter
  modport slave (
    input  left_in, right_in, data_valid_in,
    output ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out
  );

endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: registered sclk plus combinational strobes flagging the
// clk edge on which sclk rises or falls.
module i2s_clk_gen #(
  parameter int unsigned SCLK_HALF = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sclk_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          wrap_c;

  always_comb begin
    wrap_c = (div_q == CW'(SCLK_HALF - 1));
    div_d  = wrap_c ? '0 : div_q + CW'(1);
    sclk_d = wrap_c ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign rise_c_o = wrap_c & ~sclk_q;
  assign fall_c_o = wrap_c &  sclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S (Philips) bus-master transmitter: one holding register for a stereo
// pair, loaded into a frame shift register at every frame boundary.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int unsigned SCLK_HALF  = 16
) (
  input logic              clk_in,
  input logic              rst_in,
  i2s_transmitter_if.slave bus
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned PAD_W      = SLOT_WIDTH - DATA_WIDTH;

  logic                  sclk_rise_unused_c;
  logic                  sclk_fall_c;
  logic                  accept_c;
  logic [FRAME_BITS-1:0] frame_c;

  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
  logic                  ready_q, ready_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  ws_q, ws_d;
  logic                  sdata_q, sdata_d;
  logic                  fs_q, fs_d;
  logic                  ur_q, ur_d;

  i2s_clk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_clk_gen (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .sclk_o   (bus.sclk_out),
    .rise_c_o (sclk_rise_unused_c),
    .fall_c_o (sclk_fall_c)
  );

  // Handshake, bit position, word select and frame shifting
  always_comb begin
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    shift_d      = shift_q;
    pos_d        = pos_q;
    ws_d         = ws_q;
    sdata_d      = sdata_q;
    fs_d         = 1'b0;
    ur_d         = 1'b0;
    frame_c      = '0;

    accept_c = bus.data_valid_in & ready_q;
    if (accept_c) begin
      hold_full_d  = 1'b1;
      hold_left_d  = bus.left_in;
      hold_right_d = bus.right_in;
    end

    if (sclk_fall_c) begin
      pos_d = (pos_q == POS_W'(FRAME_BITS - 1)) ? '0 : pos_q + POS_W'(1);
      ws_d  = (pos_d >= POS_W'(SLOT_WIDTH - 1) && pos_d <= POS_W'(FRAME_BITS - 2))
              ? WS_RIGHT : WS_LEFT;
      if (pos_d == '0) begin
        // Only a pair held before this edge is eligible; a same-edge accept waits a frame
        fs_d = 1'b1;
        if (hold_full_q) begin
          frame_c     = {SLOT_WIDTH'(hold_left_q)  << PAD_W,
                         SLOT_WIDTH'(hold_right_q) << PAD_W};
          hold_full_d = 1'b0;
        end else begin
          ur_d = 1'b1;
        end
        sdata_d = frame_c[FRAME_BITS-1];
        shift_d = frame_c << 1;
      end else begin
        sdata_d = shift_q[FRAME_BITS-1];
        shift_d = shift_q << 1;
      end
    end

    ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      ready_q      <= 1'b1;
      shift_q      <= '0;
      pos_q        <= POS_W'(FRAME_BITS - 1);
      ws_q         <= WS_LEFT;
      sdata_q      <= 1'b0;
      fs_q         <= 1'b0;
      ur_q         <= 1'b0;
    end else begin
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      ready_q      <= ready_d;
      shift_q      <= shift_d;
      pos_q        <= pos_d;
      ws_q         <= ws_d;
      sdata_q      <= sdata_d;
      fs_q         <= fs_d;
      ur_q         <= ur_d;
    end
  end

  assign bus.ready_out       = ready_q;
  assign bus.ws_out          = ws_q;
  assign bus.sdata_out       = sdata_q;
  assign bus.frame_start_out = fs_q;
  assign bus.underrun_out    = ur_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: decodes frames at sclk rising edges and
// compares against hand-computed frames, pulse cycles and reset values.
module tb_i2s_transmitter;

  localparam int unsigned DW = 24;
  localparam int unsigned SW = 32;
  localparam int unsigned SH = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int stray  = 0;
  bit stream_en = 1'b0;

  i2s_transmitter_if #(.DATA_WIDTH(DW)) bus ();

  i2s_transmitter #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (SW),
    .SCLK_HALF  (SH)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; sample 1 time unit after the edge. Streams the next pair when enabled.
  task automatic tick();
    logic acc;
    acc = bus.data_valid_in & bus.ready_out;
    @(posedge clk_in);
    #1;
    cyc++;
    if (bus.underrun_out && !bus.frame_start_out) stray++;
    if (stream_en && acc) begin
      bus.left_in  = bus.left_in  + 24'd1;
      bus.right_in = bus.right_in - 24'd1;
    end
  endtask

  task automatic wait_fs(input string tag, input int exp_cyc, input logic exp_ur);
    int   start;
    logic ur;
    start = -1;
    ur    = 1'b0;
    for (int k = 0; k < 300 && start < 0; k++) begin
      tick();
      if (bus.frame_start_out) begin
        start = cyc;
        ur    = bus.underrun_out;
      end
    end
    check_eq({tag, "_fs_cycle"}, 64'(start), 64'(exp_cyc));
    check_eq({tag, "_underrun"}, 64'(ur), 64'(exp_ur));
  endtask

  // Collect 64 bits at sclk rising edges, checking ws against bit position.
  task automatic check_frame(input string tag, input logic [63:0] exp);
    logic [63:0] bits;
    logic        prev;
    logic        ws_exp;
    int          nbits;
    int          ws_err;
    bits   = '0;
    nbits  = 0;
    ws_err = 0;
    prev   = bus.sclk_out;
    for (int k = 0; k < 300 && nbits < 64; k++) begin
      tick();
      if (!prev && bus.sclk_out) begin
        bits[6'(63 - nbits)] = bus.sdata_out;
        ws_exp = (nbits >= 31 && nbits <= 62);
        if (bus.ws_out !== ws_exp) ws_err++;
        nbits++;
      end
      prev = bus.sclk_out;
    end
    check_eq({tag, "_nbits"}, 64'(nbits), 64'd64);
    check_eq({tag, "_data"}, bits, exp);
    check_eq({tag, "_ws_err"}, 64'(ws_err), 64'd0);
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    bus.left_in       = l;
    bus.right_in      = r;
    bus.data_valid_in = 1'b1;
    tick();
    bus.data_valid_in = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq(tag, 64'({bus.ready_out, bus.sclk_out, bus.ws_out, bus.sdata_out,
                      bus.frame_start_out, bus.underrun_out}), 64'b100000);
  endtask

  logic [23:0] exp_l [4] = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
  logic [23:0] exp_r [4] = '{24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC};
  int          exp_fs3 [4] = '{1028, 1284, 1540, 1796};

  initial begin
    bus.left_in       = '0;
    bus.right_in      = '0;
    bus.data_valid_in = 1'b0;

    // Reset held 5 cycles
    for (int i = 0; i < 5; i++) tick();
    check_reset("reset_values");
    rst_in = 1'b0;
    cyc    = 0;

    // Idle: three underrun frames of zeros
    wait_fs("idle0", 4, 1'b1);
    check_frame("idle0", 64'h0);
    wait_fs("idle1", 260, 1'b1);
    check_frame("idle1", 64'h0);
    wait_fs("idle2", 516, 1'b1);
    check_frame("idle2", 64'h0);

    // Single pair
    send(24'hA5A5A5, 24'h5A5A5A);
    check_eq("s2_ready_after_accept", 64'(bus.ready_out), 64'd0);
    wait_fs("s2", 772, 1'b0);
    tick();
    check_eq("s2_ready_after_fs", 64'(bus.ready_out), 64'd1);
    check_frame("s2", {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});

    // Continuous stream
    bus.left_in       = 24'h000001;
    bus.right_in      = 24'hFFFFFF;
    bus.data_valid_in = 1'b1;
    stream_en         = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_fs($sformatf("s3_f%0d", f), exp_fs3[f], 1'b0);
      check_frame($sformatf("s3_f%0d", f), {exp_l[f], 8'h00, exp_r[f], 8'h00});
    end
    stream_en         = 1'b0;
    bus.data_valid_in = 1'b0;

    // Valid while not ready is ignored; held pair 5 goes out
    bus.left_in       = 24'h123456;
    bus.right_in      = 24'h654321;
    bus.data_valid_in = 1'b1;
    tick();
    check_eq("s4_ready_still_low", 64'(bus.ready_out), 64'd0);
    bus.data_valid_in = 1'b0;
    wait_fs("s4", 2052, 1'b0);
    check_frame("s4", {24'h000005, 8'h00, 24'hFFFFFB, 8'h00});
    wait_fs("s4_after", 2308, 1'b1);
    check_frame("s4_after", 64'h0);

    // Accept exactly in the load cycle
    tick();
    bus.left_in       = 24'hABCDEF;
    bus.right_in      = 24'h012345;
    bus.data_valid_in = 1'b1;
    tick();
    bus.data_valid_in = 1'b0;
    check_eq("s5_cycle", 64'(cyc), 64'd2564);
    check_eq("s5_fs", 64'(bus.frame_start_out), 64'd1);
    check_eq("s5_underrun", 64'(bus.underrun_out), 64'd1);
    check_eq("s5_ready", 64'(bus.ready_out), 64'd0);
    check_frame("s5_load", 64'h0);
    wait_fs("s5_next", 2820, 1'b0);
    check_frame("s5_next", {24'hABCDEF, 8'h00, 24'h012345, 8'h00});

    // Reset mid-right-slot with a pair held
    wait_fs("s6_pre", 3076, 1'b1);
    send(24'h111111, 24'h222222);
    for (int i = 0; i < 150; i++) tick();
    check_eq("s6_ws_right", 64'(bus.ws_out), 64'd1);
    check_eq("s6_ready_held", 64'(bus.ready_out), 64'd0);
    rst_in = 1'b1;
    tick();
    check_reset("s6_reset_values");
    rst_in = 1'b0;
    cyc    = 0;
    wait_fs("s6_f0", 4, 1'b1);
    check_frame("s6_f0", 64'h0);
    wait_fs("s6_f1", 260, 1'b1);

    check_eq("stray_underrun", 64'(stray), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises stereo PCM sample pairs onto a standard I2S link (Philips format) to drive an external DAC.
- Transmit counterpart of the microphone I2S receiver. It generates its own bit clock and word select as bus master.
- Sits after the pitch-correction path as the hi-fi alternative to the PDM speaker output.
- Accepts one left/right pair per frame over a valid/ready handshake, buffered in a single holding register.

Parameters:
- DATA_WIDTH, 24: significant bits per channel sample. Two's complement, MSB first.
- SLOT_WIDTH, 32: sclk periods per channel slot. Bits below DATA_WIDTH are padded with 0. Must be >= DATA_WIDTH.
- SCLK_HALF, 16: clk_in cycles per sclk half-period. Must be >= 2. With 100 MHz this gives 3.125 MHz sclk and 48.83 kHz frames.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- left_in  input  DATA_WIDTH  left sample, signed
- right_in  input  DATA_WIDTH  right sample, signed
- data_valid_in  input  1  pair presented
- ready_out  output  1  holding register empty; transfer when data_valid_in && ready_out
- sclk_out  output  1  I2S bit clock
- ws_out  output  1  word select; 0 = left, 1 = right
- sdata_out  output  1  serial data, changes on sclk falling edge
- frame_start_out  output  1  one-cycle pulse when a new frame begins (left MSB driven)
- underrun_out  output  1  one-cycle pulse, coincident with frame_start_out, when the frame had no data

Behaviour:
- Reset values:
  - ready_out=1, sclk_out=0, ws_out=0, sdata_out=0, frame_start_out=0, underrun_out=0.
  - Holding register empty, shift register 0, div_cnt=0, bit_pos=2*SLOT_WIDTH-1.
- Reset applies mid-frame with the same values. Any held pair is discarded.
- All outputs are registered.
- Divider:
  - div_cnt counts 0..SCLK_HALF-1. When div_cnt==SCLK_HALF-1, it wraps and sclk_out toggles.
  - A toggle from 1 to 0 is the falling event. It occurs every 2*SCLK_HALF cycles.
  - The first falling event after reset is at cycle 2*SCLK_HALF.
- On each falling event:
  - bit_pos advances modulo 2*SLOT_WIDTH.
  - sdata_out is updated with the bit for the new bit_pos, in the same cycle that sclk_out goes 0.
- Frame layout by bit_pos:
  - 0..DATA_WIDTH-1: left MSB..LSB.
  - DATA_WIDTH..SLOT_WIDTH-1: 0.
  - SLOT_WIDTH..SLOT_WIDTH+DATA_WIDTH-1: right MSB..LSB.
  - Remaining positions: 0.
- ws_out timing (one-bit I2S lead):
  - ws_out=1 for bit_pos in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2].
  - ws_out=0 otherwise.
  - So ws_out rises during the last left bit and falls during the last right bit.
- Frame load, on the falling event where bit_pos becomes 0:
  - If holding full: shift register <= {left, pad, right, pad}, holding marked empty, ready_out=1 next cycle, frame_start_out=1.
  - If holding empty: shift register <= all zeros, frame_start_out=1, underrun_out=1.
- Accept: on valid&&ready, the pair is latched into holding, and ready_out=0 from the next cycle.
  - Exactly one pair is consumed per frame.
  - There is no bypass. A pair accepted in the load cycle goes to the next frame, and the current frame underruns.
- data_valid_in while ready_out=0 is ignored. The upstream must hold the pair.
- Latency: the left MSB appears on sdata_out at the first frame load after acceptance, at most 2*SCLK_HALF*2*SLOT_WIDTH cycles later.

Decomposition:
- Shared package i2s_pkg holds:
  - localparams for default SLOT_WIDTH and frame length 2*SLOT_WIDTH.
  - The ws polarity constants WS_LEFT=0 and WS_RIGHT=1, shared with i2s_receiver.
- Sub-module i2s_clk_gen: divider producing sclk_out, a rising-event strobe and a falling-event strobe.
  - Reusable by the receiver.
- The top contains the handshake/holding logic, the bit_pos counter and the shift register.

Test Plan (DATA_WIDTH=24, SLOT_WIDTH=32, SCLK_HALF=2; frame = 256 cycles):
1. Reset for 5 cycles, no valid, then run 600 cycles.
   - Expect sdata_out=0 throughout.
   - Expect frame_start_out and underrun_out pulses at cycles 4, 260 and 516.
   - Expect ws_out high exactly over bit_pos 31..62.
2. Send left=24'hA5A5A5, right=24'h5A5A5A before the first load.
   - Expect a bench sampling at sclk rising edges to decode left=A5A5A5, right=5A5A5A, with 8 zero pad bits after each channel.
   - Expect ready_out=1 again one cycle after frame_start_out.
3. Hold data_valid_in=1 continuously with an incrementing pair, starting at left=1, right=-1.
   - Expect one pair per frame and no underrun.
   - Expect the decoded sequence to be 1/FFFFFF, 2/FFFFFE, ... with no skipped or duplicated pairs.
4. Assert valid while ready_out=0 with a different pair.
   - Expect it to be ignored, and the original pair to be transmitted.
5. Accept a pair exactly in the load cycle.
   - Expect that frame to be zeros with underrun_out=1, and the pair to be transmitted in the following frame.
6. Assert rst_in mid-right-slot.
   - Expect all outputs at reset values the next cycle, holding register empty, and timing restarted as in scenario 1.
